// File: rtl/bcd_digit_entry_if.sv
// rtl/bcd_digit_entry_if.sv - key input and digit output bundle for bcd_digit_entry
interface bcd_digit_entry_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic [3:0] edit_thousands;
    logic [3:0] edit_hundreds;
    logic [3:0] edit_tens;
    logic [3:0] edit_ones;
    logic [2:0] edit_count;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       commit;
    logic       key_err;

    modport master (
        output key_valid, key_code,
        input  edit_thousands, edit_hundreds, edit_tens, edit_ones, edit_count,
        input  thousands, hundreds, tens, ones, commit, key_err
    );

    modport slave (
        input  key_valid, key_code,
        output edit_thousands, edit_hundreds, edit_tens, edit_ones, edit_count,
        output thousands, hundreds, tens, ones, commit, key_err
    );
endinterface

// File: rtl/bcd_digit_entry.sv
// rtl/bcd_digit_entry.sv - keypad BCD edit buffer with backspace, clear and enter-commit
module bcd_digit_entry #(
    parameter logic [4:0] BKSP_CODE  = 5'd10,
    parameter logic [4:0] CLR_CODE   = 5'd11,
    parameter logic [4:0] ENTER_CODE = 5'd12
) (
    input  logic            clk,
    input  logic            rst,
    bcd_digit_entry_if.slave bus
);
    // The digit counter doubles as the state: EMPTY, PARTIAL (1-3), FULL.
    localparam logic [2:0] ST_EMPTY = 3'd0;
    localparam logic [2:0] ST_FULL  = 3'd4;

    logic [3:0] r_edit_th, r_edit_hu, r_edit_te, r_edit_on;
    logic [3:0] r_cmt_th, r_cmt_hu, r_cmt_te, r_cmt_on;
    logic [2:0] r_count;
    logic       r_commit;
    logic       r_key_err;

    logic w_is_digit, w_is_bksp, w_is_clr, w_is_enter;

    assign w_is_digit = bus.key_valid && (bus.key_code <= 5'd9);
    assign w_is_bksp  = bus.key_valid && (bus.key_code == BKSP_CODE);
    assign w_is_clr   = bus.key_valid && (bus.key_code == CLR_CODE);
    assign w_is_enter = bus.key_valid && (bus.key_code == ENTER_CODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edit_th <= 4'd0;
            r_edit_hu <= 4'd0;
            r_edit_te <= 4'd0;
            r_edit_on <= 4'd0;
            r_cmt_th  <= 4'd0;
            r_cmt_hu  <= 4'd0;
            r_cmt_te  <= 4'd0;
            r_cmt_on  <= 4'd0;
            r_count   <= ST_EMPTY;
            r_commit  <= 1'b0;
            r_key_err <= 1'b0;
        end else begin
            r_commit  <= 1'b0;
            r_key_err <= 1'b0;
            if (w_is_digit) begin
                if (r_count == ST_FULL) begin
                    r_key_err <= 1'b1;
                end else begin
                    r_edit_th <= r_edit_hu;
                    r_edit_hu <= r_edit_te;
                    r_edit_te <= r_edit_on;
                    r_edit_on <= bus.key_code[3:0];
                    r_count   <= r_count + 3'd1;
                end
            end else if (w_is_bksp) begin
                if (r_count == ST_EMPTY) begin
                    r_key_err <= 1'b1;
                end else begin
                    r_edit_on <= r_edit_te;
                    r_edit_te <= r_edit_hu;
                    r_edit_hu <= r_edit_th;
                    r_edit_th <= 4'd0;
                    r_count   <= r_count - 3'd1;
                end
            end else if (w_is_clr || w_is_enter) begin
                if (w_is_enter) begin
                    r_cmt_th <= r_edit_th;
                    r_cmt_hu <= r_edit_hu;
                    r_cmt_te <= r_edit_te;
                    r_cmt_on <= r_edit_on;
                    r_commit <= 1'b1;
                end
                r_edit_th <= 4'd0;
                r_edit_hu <= 4'd0;
                r_edit_te <= 4'd0;
                r_edit_on <= 4'd0;
                r_count   <= ST_EMPTY;
            end
        end
    end

    assign bus.edit_thousands = r_edit_th;
    assign bus.edit_hundreds  = r_edit_hu;
    assign bus.edit_tens      = r_edit_te;
    assign bus.edit_ones      = r_edit_on;
    assign bus.edit_count     = r_count;
    assign bus.thousands      = r_cmt_th;
    assign bus.hundreds       = r_cmt_hu;
    assign bus.tens           = r_cmt_te;
    assign bus.ones           = r_cmt_on;
    assign bus.commit         = r_commit;
    assign bus.key_err        = r_key_err;
endmodule

// File: tb/tb_bcd_digit_entry.sv
// tb/tb_bcd_digit_entry.sv - directed self-checking bench for bcd_digit_entry
module tb_bcd_digit_entry;
    localparam logic [4:0] K_BKSP  = 5'd10;
    localparam logic [4:0] K_CLR   = 5'd11;
    localparam logic [4:0] K_ENTER = 5'd12;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    bcd_digit_entry_if u_if ();

    bcd_digit_entry u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] edit_buf();
        return {u_if.edit_thousands, u_if.edit_hundreds, u_if.edit_tens, u_if.edit_ones};
    endfunction

    function automatic logic [15:0] cmt_buf();
        return {u_if.thousands, u_if.hundreds, u_if.tens, u_if.ones};
    endfunction

    // One key per cycle; outputs are sampled 1 ns after the edge that took the key.
    task automatic press(input logic [4:0] code);
        u_if.key_valid = 1'b1;
        u_if.key_code  = code;
        @(posedge clk);
        #1;
        u_if.key_valid = 1'b0;
        u_if.key_code  = 5'd0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dec;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        u_if.key_valid = 1'b0;
        u_if.key_code  = 5'd0;
        idle();
        idle();
        rst = 1'b0;

        chk("rst_edit",   edit_buf(), 16'h0000);
        chk("rst_count",  16'(u_if.edit_count), 16'd0);
        chk("rst_cmt",    cmt_buf(), 16'h0000);
        chk("rst_flags",  {14'd0, u_if.commit, u_if.key_err}, 16'd0);

        press(5'd1);
        chk("k1_edit", edit_buf(), 16'h0001);
        press(5'd2);
        press(5'd3);
        press(5'd4);
        chk("k1234_edit",  edit_buf(), 16'h1234);
        chk("k1234_count", 16'(u_if.edit_count), 16'd4);
        press(K_ENTER);
        chk("ent1_commit", 16'(u_if.commit), 16'd1);
        chk("ent1_err",    16'(u_if.key_err), 16'd0);
        chk("ent1_cmt",    cmt_buf(), 16'h1234);
        chk("ent1_edit",   edit_buf(), 16'h0000);
        chk("ent1_count",  16'(u_if.edit_count), 16'd0);
        idle();
        chk("ent1_pulse_end", 16'(u_if.commit), 16'd0);
        chk("ent1_hold",      cmt_buf(), 16'h1234);

        press(5'd7);
        press(5'd5);
        press(K_ENTER);
        chk("ent75_cmt", cmt_buf(), 16'h0075);
        dec = int'(u_if.thousands) * 1000 + int'(u_if.hundreds) * 100
            + int'(u_if.tens) * 10 + int'(u_if.ones);
        chk("ent75_dec", 16'(dec), 16'd75);

        press(5'd9);
        press(5'd8);
        press(5'd7);
        press(5'd6);
        press(5'd5);
        chk("full_err",   16'(u_if.key_err), 16'd1);
        chk("full_edit",  edit_buf(), 16'h9876);
        chk("full_count", 16'(u_if.edit_count), 16'd4);
        press(K_BKSP);
        chk("bksp_err",   16'(u_if.key_err), 16'd0);
        chk("bksp_edit",  edit_buf(), 16'h0987);
        chk("bksp_count", 16'(u_if.edit_count), 16'd3);

        press(K_CLR);
        chk("clr_edit", edit_buf(), 16'h0000);
        chk("clr_cmt",  cmt_buf(), 16'h0075);
        press(K_BKSP);
        chk("bksp0_err",   16'(u_if.key_err), 16'd1);
        chk("bksp0_edit",  edit_buf(), 16'h0000);
        chk("bksp0_count", 16'(u_if.edit_count), 16'd0);
        press(K_ENTER);
        chk("ent0_commit", 16'(u_if.commit), 16'd1);
        chk("ent0_err",    16'(u_if.key_err), 16'd0);
        chk("ent0_cmt",    cmt_buf(), 16'h0000);

        press(5'd3);
        press(K_ENTER);
        chk("ent3_cmt", cmt_buf(), 16'h0003);
        press(5'd4);
        press(5'd2);
        press(K_CLR);
        chk("clr2_err", 16'(u_if.key_err), 16'd0);
        press(5'd6);
        chk("k6_edit",  edit_buf(), 16'h0006);
        chk("k6_count", 16'(u_if.edit_count), 16'd1);
        chk("k6_cmt",   cmt_buf(), 16'h0003);
        press(5'd20);
        chk("ign_edit",  edit_buf(), 16'h0006);
        chk("ign_count", 16'(u_if.edit_count), 16'd1);
        chk("ign_flags", {14'd0, u_if.commit, u_if.key_err}, 16'd0);

        press(5'd3);
        press(5'd1);
        chk("k31_edit", edit_buf(), 16'h0631);
        rst = 1'b1;
        press(5'd8);
        rst = 1'b0;
        chk("mrst_edit",  edit_buf(), 16'h0000);
        chk("mrst_count", 16'(u_if.edit_count), 16'd0);
        chk("mrst_cmt",   cmt_buf(), 16'h0000);
        chk("mrst_flags", {14'd0, u_if.commit, u_if.key_err}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bcd_digit_entry.md
Name: bcd_digit_entry

Overview:
- Keypad-driven decimal entry stage, directly upstream of the BCD-to-binary converter.
- Accumulates decoded key strokes into a 4-digit BCD edit buffer, with digits shifting in from the ones position.
- Supports backspace and clear.
- On enter, commits the buffer as thousands/hundreds/tens/ones with a one-cycle strobe; the converter consumes the committed digits combinationally.
- The live edit buffer is also exported for the seven-segment display path.

Parameters:
- BKSP_CODE, 5'd10, key code for backspace.
- CLR_CODE, 5'd11, key code for clear.
- ENTER_CODE, 5'd12, key code for enter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  single-cycle strobe: key_code is meaningful this cycle.
- key_code  input  5  0-9 are digits; BKSP/CLR/ENTER per parameters; any other value is ignored.
- edit_thousands  output  4  edit buffer digit 3.
- edit_hundreds  output  4  edit buffer digit 2.
- edit_tens  output  4  edit buffer digit 1.
- edit_ones  output  4  edit buffer digit 0.
- edit_count  output  3  number of digits entered, 0..4.
- thousands  output  4  committed digit 3; feeds the converter.
- hundreds  output  4  committed digit 2.
- tens  output  4  committed digit 1.
- ones  output  4  committed digit 0.
- commit  output  1  one-cycle pulse: committed digits were updated on this edge.
- key_err  output  1  one-cycle pulse: the key was rejected.

Behaviour:
- Reset (rst=1 at an edge): all edit and committed digits = 0, edit_count = 0, commit = 0, key_err = 0.
- Reset overrides any simultaneous key_valid.
- Mid-entry reset discards the buffer and the committed value.
- All outputs are registered. Nothing changes when key_valid = 0, except that commit and key_err return to 0.
- Latency: a key sampled at edge N takes effect at edge N; outputs are visible in the following cycle. commit and key_err are high for exactly that one cycle.
- Digit key d (0..9), edit_count < 4:
  - buffer shifts left one digit: thousands<=hundreds, hundreds<=tens, tens<=ones, ones<=d.
  - edit_count += 1.
  - A leading 0 counts as a digit.
- Digit key, edit_count = 4: buffer unchanged; key_err pulses.
- BKSP, edit_count > 0:
  - buffer shifts right: ones<=tens, tens<=hundreds, hundreds<=thousands, thousands<=0.
  - edit_count -= 1.
- BKSP, edit_count = 0: no change; key_err pulses.
- CLR: buffer = 0, edit_count = 0. No error, even if already empty. Committed digits unchanged.
- ENTER:
  - committed digits <= edit buffer (empty buffer commits 0000).
  - commit pulses.
  - Edit buffer and edit_count cleared on the same edge.
- Unrecognised codes (13..31): ignored silently; no key_err.
- Invariants:
  - Edit digits above position edit_count-1 are always 0, so the buffer always reads as the right-aligned decimal value.
  - Every digit output is always within 0..9.
- Back-to-back keys on consecutive cycles must each be processed; there is no busy state.
- commit and key_err are never asserted together.
- Committed digits hold their value until the next ENTER or reset.
- Implementation: small registered datapath plus a 3-bit digit counter. The counter acts as the state machine with states EMPTY(0), PARTIAL(1-3), FULL(4):
  - digit: +1, saturating at FULL.
  - BKSP: -1, saturating at EMPTY.
  - CLR / ENTER: go to EMPTY.

Test Plan:
- Reset, then keys 1,2,3,4 on consecutive cycles -> edit digits 1/2/3/4, edit_count=4; then ENTER -> commit pulse for one cycle, committed 1/2/3/4, edit buffer 0000, edit_count=0.
- Keys 7,5 then ENTER -> committed 0/0/7/5; converter downstream reads 75.
- Keys 9,8,7,6 then key 5 -> key_err pulse, buffer stays 9876; then BKSP -> 0987, edit_count=3.
- BKSP and ENTER on an empty buffer -> BKSP gives a key_err pulse and no change; ENTER gives a commit pulse with committed 0000 and no key_err.
- Keys 4,2, CLR, key 6 -> buffer 0006, edit_count=1; committed value from the earlier ENTER unchanged. Then code 20 -> no change, no key_err.
- Keys 3,1, then rst asserted the same cycle as key 8 -> all outputs 0 next cycle; the key 8 is discarded.
